// File: rtl/mux_arbiter_16.sv
// mux_arbiter_16: two-requester round-robin arbiter that drives a registered
// 16-bit shared bus through a mux_16. Each grant lasts one cycle. The word
// selected during the grant is captured on out at the edge that ends the grant.

// 2:1 word mux: sel = 0 passes a, sel = 1 passes b.
module mux_16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sel,
    output logic [15:0] mux_out
);

    // Pure steering, no state.
    assign mux_out = sel ? b : a;

endmodule

module mux_arbiter_16 (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_a,
    input  logic        req_b,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        gnt_a,
    output logic        gnt_b,
    output logic        sel,
    output logic [15:0] out,
    output logic        out_valid
);

    localparam int unsigned DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_A = 2'd1,
        SERVE_B = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                last_b_q, last_b_d;
    logic                gnt_a_q, gnt_a_d;
    logic                gnt_b_q, gnt_b_d;
    logic                sel_q, sel_d;
    logic [DATA_W-1:0]   out_q, out_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   mux_out;

    // The only path from a/b to the bus register.
    mux_16 u_mux (
        .a       (a),
        .b       (b),
        .sel     (sel_q),
        .mux_out (mux_out)
    );

    // State register and registered grant/select/bus outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            last_b_q    <= 1'b1;
            gnt_a_q     <= 1'b0;
            gnt_b_q     <= 1'b0;
            sel_q       <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_b_q    <= last_b_d;
            gnt_a_q     <= gnt_a_d;
            gnt_b_q     <= gnt_b_d;
            sel_q       <= sel_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state arbitration; ties go to whichever side was not served last.
    always_comb begin
        state_d  = IDLE;
        last_b_d = last_b_q;
        unique case ({req_a, req_b})
            2'b10:   state_d = SERVE_A;
            2'b01:   state_d = SERVE_B;
            2'b11:   state_d = last_b_q ? SERVE_A : SERVE_B;
            default: state_d = IDLE;
        endcase
        if (state_d == SERVE_A) begin
            last_b_d = 1'b0;
        end else if (state_d == SERVE_B) begin
            last_b_d = 1'b1;
        end
    end

    // Grant and select decode of the next state, so they register with it.
    always_comb begin
        gnt_a_d = 1'b0;
        gnt_b_d = 1'b0;
        sel_d   = 1'b0;
        case (state_d)
            SERVE_A: gnt_a_d = 1'b1;
            SERVE_B: begin
                gnt_b_d = 1'b1;
                sel_d   = 1'b1;
            end
            default: ;
        endcase
    end

    // Bus capture: load the muxed word at the edge that ends a grant cycle.
    always_comb begin
        out_d       = out_q;
        out_valid_d = 1'b0;
        if (state_q == SERVE_A || state_q == SERVE_B) begin
            out_d       = mux_out;
            out_valid_d = 1'b1;
        end
    end

    assign gnt_a     = gnt_a_q;
    assign gnt_b     = gnt_b_q;
    assign sel       = sel_q;
    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_arbiter_16.sv
// Self-checking bench for mux_arbiter_16: a reference arbiter model pushes the
// expected bus words to a scoreboard queue and every cycle the outputs are compared.
`timescale 1ns/1ps

module tb_mux_arbiter_16;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_a, req_b;
    logic [15:0] a, b;
    logic        gnt_a, gnt_b, sel, out_valid;
    logic [15:0] out;

    int checks = 0;
    int errors = 0;

    mux_arbiter_16 dut (
        .clk       (clk),
        .reset     (reset),
        .req_a     (req_a),
        .req_b     (req_b),
        .a         (a),
        .b         (b),
        .gnt_a     (gnt_a),
        .gnt_b     (gnt_b),
        .sel       (sel),
        .out       (out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts and reports.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: 0 = no grant, 1 = grant A, 2 = grant B.
    int          m_gnt    = 0;
    logic        m_last_b = 1'b1;
    logic        m_valid  = 1'b0;
    logic [15:0] m_out    = 16'h0000;
    logic [15:0] sb[$];
    logic        prev_gnt = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_gnt    = 0;
            m_last_b = 1'b1;
            m_valid  = 1'b0;
            sb.delete();
        end else begin
            m_valid = (m_gnt != 0);
            if (m_gnt != 0) sb.push_back((m_gnt == 2) ? b : a);
            if (req_a && req_b)  m_gnt = m_last_b ? 1 : 2;
            else if (req_a)      m_gnt = 1;
            else if (req_b)      m_gnt = 2;
            else                 m_gnt = 0;
            if (m_gnt == 1)      m_last_b = 1'b0;
            else if (m_gnt == 2) m_last_b = 1'b1;
        end
    end

    // Per-cycle compare on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (reset) begin
            m_out = 16'h0000;
        end else if (m_valid) begin
            if (sb.size() > 0) m_out = sb.pop_front();
            else chk("sb_underflow", 32'd1, 32'd0);
        end
        chk("gnt_a",     32'(gnt_a),     32'(m_gnt == 1));
        chk("gnt_b",     32'(gnt_b),     32'(m_gnt == 2));
        chk("sel",       32'(sel),       32'(m_gnt == 2));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out",       32'(out),       32'(m_out));
        chk("gnt_mutex", 32'(gnt_a & gnt_b), 32'd0);
        chk("valid_after_gnt", 32'(out_valid & ~prev_gnt), 32'd0);
        prev_gnt = reset ? 1'b0 : (gnt_a | gnt_b);
    end

    task automatic drive(input logic ra, input logic rb, input logic [15:0] da, input logic [15:0] db);
        @(negedge clk);
        req_a = ra;
        req_b = rb;
        a     = da;
        b     = db;
    endtask

    initial begin
        reset = 1'b1;
        req_a = 1'b0;
        req_b = 1'b0;
        a     = 16'h0000;
        b     = 16'h0000;
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;

        // Idle after reset.
        repeat (3) drive(1'b0, 1'b0, 16'h0000, 16'h0000);

        // Tie straight after reset: A, B, A, B back-to-back.
        repeat (4) drive(1'b1, 1'b1, 16'h1234, 16'h5555);
        repeat (3) drive(1'b0, 1'b0, 16'h1234, 16'h5555);

        // Single A pulse.
        drive(1'b1, 1'b0, 16'hAAAA, 16'h0000);
        repeat (3) drive(1'b0, 1'b0, 16'hAAAA, 16'h0000);

        // Single B pulse, then a tie that must go to A.
        drive(1'b0, 1'b1, 16'h0000, 16'h5555);
        repeat (2) drive(1'b0, 1'b0, 16'h0000, 16'h5555);
        drive(1'b1, 1'b1, 16'h0A0A, 16'h0B0B);
        @(negedge clk);
        #1 chk("tie_after_b_to_a", 32'(gnt_a), 32'd1);
        req_a = 1'b0;
        req_b = 1'b0;
        repeat (2) drive(1'b0, 1'b0, 16'h0A0A, 16'h0B0B);

        // Continuous single requester with changing data.
        for (int i = 1; i <= 6; i++) drive(1'b1, 1'b0, 16'(i * 16'h1111), 16'hFFFF);
        for (int i = 1; i <= 6; i++) drive(1'b0, 1'b1, 16'h0000, 16'(i * 16'h0101));
        repeat (2) drive(1'b0, 1'b0, 16'h0000, 16'h0000);

        // Random traffic.
        for (int i = 0; i < 60; i++)
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  16'($urandom), 16'($urandom));

        // Reset asynchronously in the middle of a B grant.
        drive(1'b0, 1'b1, 16'h0000, 16'hBEEF);
        @(negedge clk);
        chk("gnt_b_before_reset", 32'(gnt_b), 32'd1);
        req_b = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rst_gnt_b",     32'(gnt_b),     32'd0);
        chk("rst_gnt_a",     32'(gnt_a),     32'd0);
        chk("rst_sel",       32'(sel),       32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out",       32'(out),       32'd0);
        @(negedge clk);
        #1 reset = 1'b0;
        drive(1'b1, 1'b1, 16'hC0DE, 16'hD00D);
        @(negedge clk);
        #1 chk("tie_after_reset_to_a", 32'(gnt_a), 32'd1);
        req_a = 1'b0;
        req_b = 1'b0;
        repeat (3) drive(1'b0, 1'b0, 16'h0000, 16'h0000);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_arbiter_16.md
MUX_ARBITER_16 -- requirements
Module: mux_arbiter_16

Interface
REQ-001 Parameters: none; data width SHALL be fixed at 16 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_a  input  1  requester A asks for one bus transfer.
REQ-005 req_b  input  1  requester B asks for one bus transfer.
REQ-006 a  input  16  requester A data word.
REQ-007 b  input  16  requester B data word.
REQ-008 gnt_a  output  1  grant to A, registered, one cycle per transfer.
REQ-009 gnt_b  output  1  grant to B, registered, one cycle per transfer.
REQ-010 sel  output  1  select for the internal mux_16: 0 = a, 1 = b.
REQ-011 out  output  16  registered shared-bus word.
REQ-012 out_valid  output  1  out holds a freshly transferred word this cycle.

Function
REQ-013 The block SHALL instantiate mux_16 as (a, b, sel, mux_out); no other path from a or b to out is allowed.
REQ-014 FSM states SHALL be IDLE, SERVE_A and SERVE_B; gnt_a = (state == SERVE_A); gnt_b = (state == SERVE_B).
REQ-015 sel SHALL be 1 in SERVE_B and 0 in IDLE and SERVE_A.
REQ-016 Next state from any state: neither req -> IDLE; only req_a -> SERVE_A; only req_b -> SERVE_B; both -> the requester not recorded in last_b.
REQ-017 last_b SHALL be a 1-bit register; entering SERVE_A clears it, entering SERVE_B sets it, and IDLE leaves it unchanged.
REQ-018 On each rising edge in SERVE_A or SERVE_B, out SHALL load mux_out and out_valid SHALL go to 1 for the next cycle.
REQ-019 On each rising edge in IDLE, out_valid SHALL go to 0 and out SHALL hold its value.
REQ-020 Latency: req sampled high at edge N -> gnt high in cycle N..N+1 -> word on out with out_valid in cycle N+1..N+2.
REQ-021 A requester SHALL treat the edge ending its gnt cycle as the transfer; data SHALL be held stable while gnt is high.
REQ-022 A req still high after its grant SHALL be treated as a new request.
REQ-023 Continuous req_a and req_b SHALL alternate A, B, A, B with no IDLE gap; throughput is 1 word per cycle.
REQ-024 A single continuous requester SHALL be granted every cycle.
REQ-025 gnt_a and gnt_b SHALL never be high together.
REQ-026 A request SHALL wait at most one grant cycle (starvation bound 1).
REQ-027 Toggling a, b, req_a or req_b between edges SHALL not change out, out_valid or the grants; sel changes only with state.

Reset
REQ-028 While reset is high: state = IDLE, last_b = 1 (A wins the first tie), gnt_a = gnt_b = 0, sel = 0, out = 16'h0000, out_valid = 0.
REQ-029 Reset SHALL take effect immediately without a clock edge, including mid-grant; an in-flight transfer SHALL be dropped with no out_valid.
REQ-030 On the first edge after reset falls, arbitration SHALL follow REQ-016 with last_b = 1.

Verification
REQ-031 Reset test: after reset, set req_a=req_b=0 for 3 cycles -> gnt_a=gnt_b=0, out=0x0000, out_valid=0 throughout.
REQ-032 Single A request: a=0xAAAA, req_a pulsed 1 cycle -> gnt_a for 1 cycle, sel=0, then out=0xAAAA with out_valid=1 for 1 cycle.
REQ-033 Tie after reset: a=0x1234, b=0x5555, both req held for 4 grants -> grant order A, B, A, B; out sequence 0x1234, 0x5555, 0x1234, 0x5555 back-to-back.
REQ-034 Single B request: b=0x5555, req_b pulsed -> sel=1 during gnt_b, then out=0x5555 with out_valid=1; the following tie goes to A.
REQ-035 Reset mid-operation: assert reset asynchronously during gnt_b -> gnt_b, out_valid and out clear immediately; the next tie after release grants A.
REQ-036 Every test: an assertion checks each cycle that gnt_a and gnt_b are never both 1, and that out_valid=1 only in the cycle after a grant.
